// File: rtl/addsub_sequencer_pkg.sv
// Shared definitions for the add/subtract operand-entry sequencer.
//   state_e     : FSM states; the encoding doubles as the LED phase value.
//   OP_ADD/SUB  : value of the sub bit for each operation.
//   ovf7        : signed 7-bit overflow from the operands, the result and the mode.
package addsub_sequencer_pkg;

    typedef enum logic [2:0] {
        A_LO  = 3'd0,
        A_HI  = 3'd1,
        B_LO  = 3'd2,
        B_HI  = 3'd3,
        OPSEL = 3'd4,
        EXEC  = 3'd5,
        SHOW  = 3'd6
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Add overflows when the operand signs agree and the result sign differs.
    // Subtract overflows when the operand signs differ and the result sign
    // differs from A.
    function automatic logic ovf7(input logic [6:0] a, input logic [6:0] b,
                                  input logic [6:0] s, input logic sub);
        if (sub == OP_SUB)
            return (a[6] != b[6]) && (s[6] != a[6]);
        else
            return (a[6] == b[6]) && (s[6] != a[6]);
    endfunction

endpackage

// File: rtl/addsub_sequencer_if.sv
// Board-side bus of the sequencer: rotary/switch inputs, datapath link and
// display outputs.
//   master : the sequencer (drives operands, mode, start and display)
//   slave  : board/datapath side (drives rot_event, Y, dp_sum, dp_carry)
interface addsub_sequencer_if;
    logic       rot_event;
    logic [3:0] Y;
    logic [6:0] dp_sum;
    logic       dp_carry;
    logic [6:0] op_a;
    logic [6:0] op_b;
    logic       sub;
    logic       start;
    logic [6:0] result;
    logic       carry_out;
    logic       overflow;
    logic       done;
    logic [2:0] phase;

    modport master (
        input  rot_event, Y, dp_sum, dp_carry,
        output op_a, op_b, sub, start, result, carry_out, overflow, done, phase
    );

    modport slave (
        output rot_event, Y, dp_sum, dp_carry,
        input  op_a, op_b, sub, start, result, carry_out, overflow, done, phase
    );
endinterface

// File: rtl/addsub_sequencer_rise_detect.sv
// rise_detect: registered 1-bit rising-edge detector.
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : level input (assumed synchronous to clk)
//   rise       : high for the single cycle where d is 1 and was 0 last cycle
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);
    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_q <= 1'b0;
        else        d_q <= d;
    end

    assign rise = d & ~d_q;
endmodule

// File: rtl/addsub_sequencer.sv
// addsub_sequencer: rotation-driven operand entry and execution controller for
// the 7-bit adder/subtractor datapath.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : rot_event/Y from the board, dp_sum/dp_carry from the datapath;
//                op_a/op_b/sub/start to the datapath; result/carry_out/
//                overflow/done/phase to the display.
// Each rotation edge captures Y into the next field (A lo, A hi, B lo, B hi,
// op); the block then pulses start, waits DP_LATENCY+1 cycles and latches
// the result until the next rotation edge.
module addsub_sequencer
    import addsub_sequencer_pkg::*;
#(
    parameter int DP_LATENCY = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    addsub_sequencer_if.master  bus
);
    localparam logic [3:0] LAT = 4'(DP_LATENCY);

    state_e     state, state_nxt;
    logic       ev;
    logic [3:0] cnt;
    logic [6:0] op_a, op_b, result;
    logic       sub, start, carry_out, overflow;

    rise_detect u_rise (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (bus.rot_event),
        .rise (ev)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= A_LO;
        else        state <= state_nxt;
    end

    // Events in EXEC are dropped; SHOW only restarts, it captures nothing.
    always_comb begin
        state_nxt = state;
        case (state)
            A_LO:    if (ev) state_nxt = A_HI;
            A_HI:    if (ev) state_nxt = B_LO;
            B_LO:    if (ev) state_nxt = B_HI;
            B_HI:    if (ev) state_nxt = OPSEL;
            OPSEL:   if (ev) state_nxt = EXEC;
            EXEC:    if (cnt == 4'd0) state_nxt = SHOW;
            SHOW:    if (ev) state_nxt = A_LO;
            default: state_nxt = A_LO;
        endcase
    end

    // Field capture, latency counter and result latch. Operands are only
    // overwritten field by field, so they stay stable from OPSEL to SHOW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a      <= '0;
            op_b      <= '0;
            sub       <= 1'b0;
            start     <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            start <= 1'b0;
            case (state)
                A_LO:  if (ev) op_a[3:0] <= bus.Y;
                A_HI:  if (ev) op_a[6:4] <= bus.Y[2:0];
                B_LO:  if (ev) op_b[3:0] <= bus.Y;
                B_HI:  if (ev) op_b[6:4] <= bus.Y[2:0];
                OPSEL: if (ev) begin
                    sub   <= bus.Y[0];
                    start <= 1'b1;
                    cnt   <= LAT;
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        result    <= bus.dp_sum;
                        carry_out <= bus.dp_carry;
                        overflow  <= ovf7(op_a, op_b, bus.dp_sum, sub);
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.op_a      = op_a;
    assign bus.op_b      = op_b;
    assign bus.sub       = sub;
    assign bus.start     = start;
    assign bus.result    = result;
    assign bus.carry_out = carry_out;
    assign bus.overflow  = overflow;
    assign bus.done      = (state == SHOW);
    assign bus.phase     = state;
endmodule

// File: tb/tb_addsub_sequencer.sv
// Directed bench for addsub_sequencer. Two instances share Y and the main
// rotation line: u_dut1 (DP_LATENCY=1) and u_dut4 (DP_LATENCY=4); u_dut4 also
// sees extra rotation pulses used to poke it while it sits in EXEC.
// Each instance has a combinational datapath model (sum/difference, carry).
module tb_addsub_sequencer;
    logic       clk;
    logic       rst_n;
    logic       rot;
    logic       rot4x;
    logic [3:0] y;
    int         total;
    int         bad;
    int         sc1, sc4, s1, s4;

    addsub_sequencer_if if1 ();
    addsub_sequencer_if if4 ();

    assign if1.rot_event = rot;
    assign if1.Y         = y;
    assign if4.rot_event = rot | rot4x;
    assign if4.Y         = y;

    assign {if1.dp_carry, if1.dp_sum} = if1.sub ? ({1'b0, if1.op_a} + {1'b0, ~if1.op_b} + 8'd1)
                                                : ({1'b0, if1.op_a} + {1'b0, if1.op_b});
    assign {if4.dp_carry, if4.dp_sum} = if4.sub ? ({1'b0, if4.op_a} + {1'b0, ~if4.op_b} + 8'd1)
                                                : ({1'b0, if4.op_a} + {1'b0, if4.op_b});

    addsub_sequencer #(.DP_LATENCY(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));
    addsub_sequencer #(.DP_LATENCY(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // start is a registered one-cycle pulse, so it spans exactly one negedge.
    initial begin sc1 = 0; sc4 = 0; end
    always @(negedge clk) begin
        if (if1.start) sc1++;
        if (if4.start) sc4++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse(input logic [3:0] v);
        @(negedge clk);
        y   = v;
        rot = 1'b1;
        @(negedge clk);
        rot = 1'b0;
    endtask

    task automatic pulse4x();
        @(negedge clk);
        rot4x = 1'b1;
        @(negedge clk);
        rot4x = 1'b0;
    endtask

    // Five events: A lo, A hi, B lo, B hi, op. Returns just after the edge
    // that enters EXEC.
    task automatic enter(input logic [6:0] a, input logic [6:0] b, input logic op);
        pulse(a[3:0]);
        pulse({1'b0, a[6:4]});
        pulse(b[3:0]);
        pulse({1'b0, b[6:4]});
        pulse({3'b000, op});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; rot = 1'b0; rot4x = 1'b0; y = 4'h0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_op_a",   32'(if1.op_a), 32'h0);
        chk("rst_op_b",   32'(if1.op_b), 32'h0);
        chk("rst_sub",    32'(if1.sub), 32'h0);
        chk("rst_start",  32'(if1.start), 32'h0);
        chk("rst_result", 32'(if1.result), 32'h0);
        chk("rst_carry",  32'(if1.carry_out), 32'h0);
        chk("rst_ovf",    32'(if1.overflow), 32'h0);
        chk("rst_done",   32'(if1.done), 32'h0);
        chk("rst_phase",  32'(if1.phase), 32'h0);
        chk("rst_phase4", 32'(if4.phase), 32'h0);
        rst_n = 1'b1;

        // add 0x25 + 0x13
        s1 = sc1; s4 = sc4;
        enter(7'h25, 7'h13, 1'b0);
        chk("add_op_a",  32'(if1.op_a), 32'h25);
        chk("add_op_b",  32'(if1.op_b), 32'h13);
        chk("add_sub",   32'(if1.sub), 32'h0);
        chk("add_start", 32'(if1.start), 32'h1);
        chk("add_exec",  32'(if1.phase), 32'h5);
        @(negedge clk);
        chk("add_start_off", 32'(if1.start), 32'h0);
        chk("add_not_done",  32'(if1.done), 32'h0);
        @(negedge clk);
        chk("add_result", 32'(if1.result), 32'h38);
        chk("add_carry",  32'(if1.carry_out), 32'h0);
        chk("add_ovf",    32'(if1.overflow), 32'h0);
        chk("add_done",   32'(if1.done), 32'h1);
        chk("add_phase",  32'(if1.phase), 32'h6);
        chk("add4_busy",  32'(if4.phase), 32'h5);
        chk("add4_ndone", 32'(if4.done), 32'h0);
        repeat (3) @(negedge clk);
        chk("add4_done",   32'(if4.done), 32'h1);
        chk("add4_result", 32'(if4.result), 32'h38);
        chk("add_starts1", 32'(sc1 - s1), 32'h1);
        chk("add_starts4", 32'(sc4 - s4), 32'h1);

        // restart from SHOW: no capture, result holds
        pulse(4'h9);
        chk("show_phase",  32'(if1.phase), 32'h0);
        chk("show_done",   32'(if1.done), 32'h0);
        chk("show_hold",   32'(if1.result), 32'h38);
        chk("show_op_a",   32'(if1.op_a), 32'h25);

        // subtract 0x25 - 0x13
        enter(7'h25, 7'h13, 1'b1);
        chk("sub_sub", 32'(if1.sub), 32'h1);
        repeat (2) @(negedge clk);
        chk("sub_result", 32'(if1.result), 32'h12);
        chk("sub_carry",  32'(if1.carry_out), 32'h1);
        chk("sub_ovf",    32'(if1.overflow), 32'h0);
        repeat (3) @(negedge clk);

        // signed overflow, add and subtract
        pulse(4'h0);
        enter(7'h3F, 7'h01, 1'b0);
        repeat (5) @(negedge clk);
        chk("ovfa_result", 32'(if1.result), 32'h40);
        chk("ovfa_ovf",    32'(if1.overflow), 32'h1);
        chk("ovfa_carry",  32'(if1.carry_out), 32'h0);
        pulse(4'h0);
        enter(7'h40, 7'h01, 1'b1);
        repeat (5) @(negedge clk);
        chk("ovfs_result", 32'(if1.result), 32'h3F);
        chk("ovfs_ovf",    32'(if1.overflow), 32'h1);
        chk("ovfs_carry",  32'(if1.carry_out), 32'h1);

        // Y[3] ignored on the high field; held rot_event counts once
        pulse(4'h0);
        pulse(4'h0);
        pulse(4'hF);
        chk("mask_op_a", 32'(if1.op_a), 32'h70);
        chk("mask_phase", 32'(if1.phase), 32'h2);
        @(negedge clk);
        y = 4'h0; rot = 1'b1;
        repeat (10) @(negedge clk);
        rot = 1'b0;
        chk("held_phase", 32'(if1.phase), 32'h3);
        pulse(4'h0);
        pulse(4'h0);
        repeat (5) @(negedge clk);
        chk("held_result", 32'(if1.result), 32'h70);
        chk("held_ovf",    32'(if1.overflow), 32'h0);

        // events during EXEC (latency 4) are ignored
        pulse(4'h0);
        s4 = sc4;
        enter(7'h0A, 7'h05, 1'b1);
        pulse4x();
        chk("exec_ign_phase", 32'(if4.phase), 32'h5);
        pulse4x();
        chk("exec_ign_phase2", 32'(if4.phase), 32'h5);
        chk("exec_ign_ndone",  32'(if4.done), 32'h0);
        @(negedge clk);
        chk("exec_ign_done",   32'(if4.done), 32'h1);
        chk("exec_ign_show",   32'(if4.phase), 32'h6);
        chk("exec_ign_result", 32'(if4.result), 32'h05);
        chk("exec_ign_starts", 32'(sc4 - s4), 32'h1);

        // asynchronous reset while u_dut4 is in EXEC
        pulse(4'h0);
        enter(7'h11, 7'h22, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_phase4",  32'(if4.phase), 32'h0);
        chk("arst_op_a4",   32'(if4.op_a), 32'h0);
        chk("arst_sub4",    32'(if4.sub), 32'h0);
        chk("arst_result4", 32'(if4.result), 32'h0);
        chk("arst_ovf4",    32'(if4.overflow), 32'h0);
        chk("arst_start1",  32'(if1.start), 32'h0);
        chk("arst_phase1",  32'(if1.phase), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        enter(7'h11, 7'h22, 1'b0);
        repeat (2) @(negedge clk);
        chk("post_result", 32'(if1.result), 32'h33);
        chk("post_done",   32'(if1.done), 32'h1);
        repeat (3) @(negedge clk);
        chk("post_result4", 32'(if4.result), 32'h33);
        chk("post_phase4",  32'(if4.phase), 32'h6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
